// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word loads and stores into aligned word
// accesses, with lane extraction, sign/zero extension and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter logic [31:0] FAULT_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_acc
);
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] FAULT  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf;
    logic        misalign;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign busy      = (state != IDLE);
    assign mem_rd    = (state == LOAD) || (state == RMW_RD);
    // Gate with reset so a reset edge landing in WRITE never commits the store.
    assign mem_wr    = (state == WRITE) && mem_acc && !reset;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wbuf;

    always_comb begin
        misalign = 1'b0;
        if (CHECK_ALIGN) begin
            case (op)
                OP_LW, OP_SW:         misalign = (addr[1:0] != 2'b00);
                OP_LH, OP_LHU, OP_SH: misalign = addr[0];
                default:              misalign = 1'b0;
            endcase
        end
    end

    always_comb begin
        shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'h0, byte_v};
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'h0, half_v};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (op_q == OP_SB)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wbuf    <= 32'h0;
            done    <= 1'b0;
            fault   <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q    <= op;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (misalign)
                            state <= FAULT;
                        else if (op < OP_SB)
                            state <= LOAD;
                        else if (op == OP_SW) begin
                            state <= WRITE;
                            wbuf  <= wdata;
                        end else
                            state <= RMW_RD;
                    end
                end
                LOAD: begin
                    rdata <= mem_acc ? load_val : FAULT_RDATA;
                    fault <= !mem_acc;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                RMW_RD: begin
                    if (mem_acc) begin
                        wbuf  <= merged;
                        state <= WRITE;
                    end else begin
                        done  <= 1'b1;
                        fault <= 1'b1;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    fault <= !mem_acc;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                FAULT: begin
                    // Only loads report FAULT_RDATA; a faulting store leaves rdata alone.
                    if (op_q < OP_SB)
                        rdata <= FAULT_RDATA;
                    fault <= 1'b1;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a scoreboard against a small
// word memory model, plus hand-written busy/back-to-back and mid-write reset sequences.
module tb_load_store_unit;
    localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3,
                           OP_LHU = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

    logic        clk;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, fault, mem_rd, mem_wr, mem_acc;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    load_store_unit #(.CHECK_ALIGN(1'b1), .FAULT_RDATA(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_acc(mem_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 0x1001_xxxx and 0x7FFF_Fxxx are accessible, folded into 64 words.
    logic [31:0] mem [0:63];
    logic [5:0]  idx;
    assign idx       = {mem_addr[30], mem_addr[6:2]};
    assign mem_acc   = (mem_addr[31:16] == 16'h1001) || (mem_addr[31:12] == 20'h7FFFF);
    assign mem_rdata = mem[idx];
    always @(posedge clk) if (mem_wr) mem[idx] <= mem_wdata;

    int          wr_tot = 0;
    int          rd_tot = 0;
    logic [31:0] last_wa = 32'h0;
    always @(posedge clk) begin
        if (mem_wr) begin
            wr_tot  <= wr_tot + 1;
            last_wa <= mem_addr;
        end
        if (mem_rd) rd_tot <= rd_tot + 1;
    end

    function automatic logic [31:0] peek(input logic [31:0] a);
        return mem[{a[30], a[6:2]}];
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        efault;
        logic        chk_rd;
        logic [31:0] erdata;
        int          lat;
        int          nwr;
        int          nrd;
        logic        chk_mem;
        logic [31:0] emem;
    } vec_t;

    vec_t vt [22];
    vec_t sbq [$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one request at a negedge; returns at the negedge where done is seen.
    task automatic access(input vec_t v, input string nm);
        int   n;
        int   wr0;
        int   rd0;
        vec_t e;
        sbq.push_back(v);
        wr0 = wr_tot;
        rd0 = rd_tot;
        req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        n = 1;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        chk({nm, " latency"}, n, e.lat);
        chk({nm, " fault"}, {31'h0, fault}, {31'h0, e.efault});
        if (e.chk_rd) chk({nm, " rdata"}, rdata, e.erdata);
        chk({nm, " writes"}, wr_tot - wr0, e.nwr);
        chk({nm, " reads"}, rd_tot - rd0, e.nrd);
        if (e.nwr > 0) chk({nm, " wr_addr"}, last_wa, {e.addr[31:2], 2'b00});
        if (e.chk_mem) chk({nm, " mem"}, peek(e.addr), e.emem);
    endtask

    initial begin
        vec_t v;
        int   wr0;
        vt[0]  = '{OP_SW,  32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,          2, 1, 0, 1'b1, 32'hDEAD_BEEF};
        vt[1]  = '{OP_LW,  32'h1001_0004, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF,  2, 0, 1, 1'b0, 32'h0};
        vt[2]  = '{OP_SW,  32'h7FFF_F000, 32'h1234_80FF, 1'b0, 1'b0, 32'h0,          2, 1, 0, 1'b1, 32'h1234_80FF};
        vt[3]  = '{OP_LB,  32'h7FFF_F001, 32'h0,         1'b0, 1'b1, 32'hFFFF_FF80,  2, 0, 1, 1'b0, 32'h0};
        vt[4]  = '{OP_LBU, 32'h7FFF_F001, 32'h0,         1'b0, 1'b1, 32'h0000_0080,  2, 0, 1, 1'b0, 32'h0};
        vt[5]  = '{OP_LH,  32'h7FFF_F002, 32'h0,         1'b0, 1'b1, 32'h0000_1234,  2, 0, 1, 1'b0, 32'h0};
        vt[6]  = '{OP_LHU, 32'h7FFF_F000, 32'h0,         1'b0, 1'b1, 32'h0000_80FF,  2, 0, 1, 1'b0, 32'h0};
        vt[7]  = '{OP_LH,  32'h7FFF_F000, 32'h0,         1'b0, 1'b1, 32'hFFFF_80FF,  2, 0, 1, 1'b0, 32'h0};
        vt[8]  = '{OP_LB,  32'h7FFF_F000, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF,  2, 0, 1, 1'b0, 32'h0};
        vt[9]  = '{OP_SW,  32'h1001_0000, 32'h1122_3344, 1'b0, 1'b0, 32'h0,          2, 1, 0, 1'b1, 32'h1122_3344};
        vt[10] = '{OP_SB,  32'h1001_0002, 32'hFFFF_FFAB, 1'b0, 1'b0, 32'h0,          3, 1, 1, 1'b1, 32'h11AB_3344};
        vt[11] = '{OP_SH,  32'h1001_0000, 32'h5555_CAFE, 1'b0, 1'b0, 32'h0,          3, 1, 1, 1'b1, 32'h11AB_CAFE};
        vt[12] = '{OP_LW,  32'h1001_0000, 32'h0,         1'b0, 1'b1, 32'h11AB_CAFE,  2, 0, 1, 1'b0, 32'h0};
        vt[13] = '{OP_SW,  32'h2000_0000, 32'hDEAD_DEAD, 1'b1, 1'b1, 32'h11AB_CAFE,  2, 0, 0, 1'b1, 32'h11AB_CAFE};
        vt[14] = '{OP_LW,  32'h1001_0002, 32'h0,         1'b1, 1'b1, 32'h0,          2, 0, 0, 1'b0, 32'h0};
        vt[15] = '{OP_LBU, 32'h1001_0003, 32'h0,         1'b0, 1'b1, 32'h0000_0011,  2, 0, 1, 1'b0, 32'h0};
        vt[16] = '{OP_SH,  32'h1001_0001, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_0011,  2, 0, 0, 1'b1, 32'h11AB_CAFE};
        vt[17] = '{OP_LB,  32'h2000_0000, 32'h0,         1'b1, 1'b1, 32'h0,          2, 0, 1, 1'b0, 32'h0};
        vt[18] = '{OP_LHU, 32'h7FFF_F003, 32'h0,         1'b1, 1'b1, 32'h0,          2, 0, 0, 1'b0, 32'h0};
        vt[19] = '{OP_SB,  32'h2000_0001, 32'h0000_0055, 1'b1, 1'b0, 32'h0,          2, 0, 1, 1'b1, 32'h11AB_CAFE};
        vt[20] = '{OP_LH,  32'h1001_0002, 32'h0,         1'b0, 1'b1, 32'h0000_11AB,  2, 0, 1, 1'b0, 32'h0};
        vt[21] = '{OP_LW,  32'h7FFF_F000, 32'h0,         1'b0, 1'b1, 32'h1234_80FF,  2, 0, 1, 1'b0, 32'h0};

        reset = 1'b1; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst fault", {31'h0, fault}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst mem_rd/wr", {30'h0, mem_rd, mem_wr}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 22; i++) access(vt[i], $sformatf("v%0d", i));

        // req held high across an SB: ignored while busy, taken again in the done cycle.
        @(negedge clk);
        req = 1'b1; op = OP_SB; addr = 32'h1001_0001; wdata = 32'h0000_0077;
        @(posedge clk);
        #1 op = OP_LW; addr = 32'h1001_0000;
        @(negedge clk);
        chk("b2b busy n1", {31'h0, busy}, 32'h1);
        chk("b2b done n1", {31'h0, done}, 32'h0);
        @(negedge clk);
        chk("b2b done n2", {31'h0, done}, 32'h0);
        @(negedge clk);
        chk("b2b sb done", {31'h0, done}, 32'h1);
        chk("b2b sb fault", {31'h0, fault}, 32'h0);
        chk("b2b sb mem", peek(32'h1001_0000), 32'h11AB_77FE);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("b2b done pulse", {31'h0, done}, 32'h0);
        chk("b2b lw busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("b2b lw done", {31'h0, done}, 32'h1);
        chk("b2b lw rdata", rdata, 32'h11AB_77FE);

        // Reset landing in the WRITE cycle of an SB must drop the store.
        @(negedge clk);
        wr0 = wr_tot;
        req = 1'b1; op = OP_SB; addr = 32'h1001_0000; wdata = 32'h0000_0099;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmw mem_wr in WRITE", {31'h0, mem_wr}, 32'h1);
        reset = 1'b1;
        #1 chk("rmw mem_wr gated", {31'h0, mem_wr}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("rmw rst busy", {31'h0, busy}, 32'h0);
        chk("rmw rst done", {31'h0, done}, 32'h0);
        chk("rmw rst rdata", rdata, 32'h0);
        chk("rmw rst writes", wr_tot - wr0, 32'h0);
        chk("rmw rst mem", peek(32'h1001_0000), 32'h11AB_77FE);
        @(negedge clk);
        v = '{OP_LW, 32'h1001_0000, 32'h0, 1'b0, 1'b1, 32'h11AB_77FE, 2, 0, 1, 1'b0, 32'h0};
        access(v, "post-rst lw");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
